// File: rtl/peripheral_mpi_ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge FSM state type for the MPI buffer front-end.
package peripheral_mpi_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WCAP   = 3'd1;
    localparam state_t ST_ACCESS = 3'd2;
    localparam state_t ST_RESP   = 3'd3;
    localparam state_t ST_ERR1   = 3'd4;
    localparam state_t ST_ERR2   = 3'd5;

endpackage

// File: rtl/peripheral_mpi_ahb_bridge.sv
// AHB-Lite slave that turns pipelined AHB transfers into single-phase bus_en/bus_ack/bus_err
// requests toward the MPI buffer, with wait states, two-cycle ERROR and a bounded timeout.
module peripheral_mpi_ahb_bridge
    import peripheral_mpi_ahb_pkg::*;
#(
    parameter int PLEN    = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb_hsel_i,
    input  logic [PLEN-1:0] ahb_haddr_i,
    input  logic [XLEN-1:0] ahb_hwdata_i,
    input  logic            ahb_hwrite_i,
    input  logic [2:0]      ahb_hsize_i,
    input  logic [1:0]      ahb_htrans_i,
    input  logic            ahb_hready_i,
    output logic [XLEN-1:0] ahb_hrdata_o,
    output logic            ahb_hreadyout_o,
    output logic            ahb_hresp_o,
    output logic [PLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic            bus_en,
    output logic [XLEN-1:0] bus_data_in,
    input  logic [XLEN-1:0] bus_data_out,
    input  logic            bus_ack,
    input  logic            bus_err
);

    localparam int         CW       = $clog2(TIMEOUT + 1);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PLEN-1:0] addr_q, addr_d;
    logic            write_q, write_d;
    logic [XLEN-1:0] hrdata_q, hrdata_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic accept;
    logic illegal;

    function automatic logic misaligned(input logic [2:0] lo, input logic [2:0] size);
        case (size)
            HSIZE_BYTE:  misaligned = 1'b0;
            HSIZE_HWORD: misaligned = lo[0];
            HSIZE_WORD:  misaligned = |lo[1:0];
            HSIZE_DWORD: misaligned = |lo[2:0];
            default:     misaligned = 1'b1;
        endcase
    endfunction

    // Only IDLE and RESP have an open address-phase slot; elsewhere the bus is stalled or cancelled.
    assign accept = ahb_hsel_i && ahb_hready_i
                 && (ahb_htrans_i == HTRANS_NONSEQ || ahb_htrans_i == HTRANS_SEQ)
                 && (state_q == ST_IDLE || state_q == ST_RESP);

    // No byte strobes on the generic bus, so only full-width writes can be forwarded.
    assign illegal = (ahb_hsize_i > MAX_SIZE)
                  || misaligned(ahb_haddr_i[2:0], ahb_hsize_i)
                  || (ahb_hwrite_i && ahb_hsize_i < MAX_SIZE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        hrdata_d = hrdata_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = ahb_haddr_i;
                    write_d = ahb_hwrite_i;
                    if (illegal)
                        state_d = ST_ERR1;
                    else if (ahb_hwrite_i)
                        state_d = ST_WCAP;
                    else
                        state_d = ST_ACCESS;
                end
            end
            ST_WCAP: begin
                wdata_d = ahb_hwdata_i;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_err) begin
                    state_d = ST_ERR1;
                    cnt_d   = '0;
                end else if (bus_ack) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    if (!write_q)
                        hrdata_d = bus_data_out;
                end else if (cnt_q + 1'b1 == TO_LIM) begin
                    state_d = ST_ERR1;
                    cnt_d   = '0;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus_en          = (state_q == ST_ACCESS);
    assign bus_we          = bus_en && write_q;
    assign bus_addr        = addr_q;
    assign bus_data_in     = wdata_q;
    assign ahb_hrdata_o    = hrdata_q;
    assign ahb_hreadyout_o = !(state_q == ST_WCAP || state_q == ST_ACCESS || state_q == ST_ERR1);
    assign ahb_hresp_o     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_peripheral_mpi_ahb_bridge.sv
// Directed bench for the AHB-to-generic bridge: reads, writes, illegal transfers, timeout,
// error precedence, back-to-back pipelining and mid-transfer reset.
module tb_peripheral_mpi_ahb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic        bus_en;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_ack;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Single slave on the segment: bus-wide HREADY is this slave's HREADYOUT.
    assign hready = hreadyout;

    peripheral_mpi_ahb_bridge #(.PLEN(32), .XLEN(32), .TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .ahb_hsel_i      (hsel),
        .ahb_haddr_i     (haddr),
        .ahb_hwdata_i    (hwdata),
        .ahb_hwrite_i    (hwrite),
        .ahb_hsize_i     (hsize),
        .ahb_htrans_i    (htrans),
        .ahb_hready_i    (hready),
        .ahb_hrdata_o    (hrdata),
        .ahb_hreadyout_o (hreadyout),
        .ahb_hresp_o     (hresp),
        .bus_addr        (bus_addr),
        .bus_we          (bus_we),
        .bus_en          (bus_en),
        .bus_data_in     (bus_data_in),
        .bus_data_out    (bus_data_out),
        .bus_ack         (bus_ack),
        .bus_err         (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle_phase();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic chk_ctl(input string tag, input logic en, input logic rdy, input logic rsp);
        chk({tag, "_en"}, {63'd0, bus_en}, {63'd0, en});
        chk({tag, "_rdy"}, {63'd0, hreadyout}, {63'd0, rdy});
        chk({tag, "_resp"}, {63'd0, hresp}, {63'd0, rsp});
    endtask

    initial begin
        rst = 1'b0; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = 3'd2; htrans = 2'b00; bus_data_out = '0; bus_ack = 1'b0; bus_err = 1'b0;
        step(); step();
        rst = 1'b1;

        chk_ctl("reset", 1'b0, 1'b1, 1'b0);
        chk("reset_hrdata", {32'd0, hrdata}, 64'd0);
        chk("reset_we", {63'd0, bus_we}, 64'd0);
        chk("reset_addr", {32'd0, bus_addr}, 64'd0);
        chk("reset_wdata", {32'd0, bus_data_in}, 64'd0);

        // Read 0x10, acked on first ACCESS cycle.
        addr_phase(32'h10, 1'b0, 3'd2);
        step();
        idle_phase();
        bus_ack = 1'b1; bus_data_out = 32'hCAFE0001;
        chk_ctl("rd_access", 1'b1, 1'b0, 1'b0);
        chk("rd_addr", {32'd0, bus_addr}, 64'h10);
        chk("rd_we", {63'd0, bus_we}, 64'd0);
        step();
        bus_ack = 1'b0; bus_data_out = 32'h0;
        chk_ctl("rd_resp", 1'b0, 1'b1, 1'b0);
        chk("rd_hrdata", {32'd0, hrdata}, 64'hCAFE0001);
        step();
        chk_ctl("rd_idle", 1'b0, 1'b1, 1'b0);

        // Write 0x20, ack on the third ACCESS cycle.
        addr_phase(32'h20, 1'b1, 3'd2);
        step();
        idle_phase();
        hwdata = 32'h12345678;
        chk_ctl("wr_wcap", 1'b0, 1'b0, 1'b0);
        step();
        hwdata = 32'hFFFF0000;
        for (int i = 0; i < 3; i++) begin
            bus_ack = (i == 2);
            chk_ctl("wr_access", 1'b1, 1'b0, 1'b0);
            chk("wr_we", {63'd0, bus_we}, 64'd1);
            chk("wr_data", {32'd0, bus_data_in}, 64'h12345678);
            chk("wr_addr", {32'd0, bus_addr}, 64'h20);
            step();
        end
        bus_ack = 1'b0;
        chk_ctl("wr_resp", 1'b0, 1'b1, 1'b0);
        chk("wr_hrdata_hold", {32'd0, hrdata}, 64'hCAFE0001);
        step();

        // Illegal: byte write at 0x21, then misaligned word read at 0x22.
        addr_phase(32'h21, 1'b1, 3'd0);
        step();
        idle_phase();
        chk_ctl("bw_err1", 1'b0, 1'b0, 1'b1);
        step();
        chk_ctl("bw_err2", 1'b0, 1'b1, 1'b1);
        step();
        chk_ctl("bw_idle", 1'b0, 1'b1, 1'b0);
        addr_phase(32'h22, 1'b0, 3'd2);
        step();
        idle_phase();
        chk_ctl("mis_err1", 1'b0, 1'b0, 1'b1);
        step();
        chk_ctl("mis_err2", 1'b0, 1'b1, 1'b1);
        step();

        // Timeout: no ack for 16 ACCESS cycles.
        addr_phase(32'h30, 1'b0, 3'd2);
        step();
        idle_phase();
        for (int i = 0; i < 16; i++) begin
            chk_ctl("to_access", 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_ctl("to_err1", 1'b0, 1'b0, 1'b1);
        step();
        chk_ctl("to_err2", 1'b0, 1'b1, 1'b1);
        step();

        // bus_err wins over simultaneous bus_ack; read data not captured.
        addr_phase(32'h40, 1'b0, 3'd2);
        step();
        idle_phase();
        bus_ack = 1'b1; bus_err = 1'b1; bus_data_out = 32'hDEADBEEF;
        chk_ctl("ea_access", 1'b1, 1'b0, 1'b0);
        step();
        bus_ack = 1'b0; bus_err = 1'b0;
        chk_ctl("ea_err1", 1'b0, 1'b0, 1'b1);
        chk("ea_hrdata", {32'd0, hrdata}, 64'hCAFE0001);
        step();
        chk_ctl("ea_err2", 1'b0, 1'b1, 1'b1);
        step();

        // Back-to-back reads, second address phase during RESP.
        addr_phase(32'h0, 1'b0, 3'd2);
        step();
        idle_phase();
        bus_ack = 1'b1; bus_data_out = 32'h11111111;
        chk("b2b_addr0", {32'd0, bus_addr}, 64'h0);
        step();
        addr_phase(32'h4, 1'b0, 3'd2);
        bus_ack = 1'b0;
        chk_ctl("b2b_resp0", 1'b0, 1'b1, 1'b0);
        chk("b2b_hrdata0", {32'd0, hrdata}, 64'h11111111);
        step();
        idle_phase();
        bus_ack = 1'b1; bus_data_out = 32'h22222222;
        chk_ctl("b2b_access1", 1'b1, 1'b0, 1'b0);
        chk("b2b_addr1", {32'd0, bus_addr}, 64'h4);
        step();
        bus_ack = 1'b0;
        chk_ctl("b2b_resp1", 1'b0, 1'b1, 1'b0);
        chk("b2b_hrdata1", {32'd0, hrdata}, 64'h22222222);
        step();

        // Reset during ACCESS aborts the request.
        addr_phase(32'h50, 1'b0, 3'd2);
        step();
        idle_phase();
        chk_ctl("rst_access", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_ctl("rst_after", 1'b0, 1'b1, 1'b0);
        chk("rst_hrdata", {32'd0, hrdata}, 64'd0);
        step();
        chk_ctl("rst_idle2", 1'b0, 1'b1, 1'b0);
        addr_phase(32'h54, 1'b0, 3'd2);
        step();
        idle_phase();
        bus_ack = 1'b1; bus_data_out = 32'h5555AAAA;
        chk_ctl("post_rst_access", 1'b1, 1'b0, 1'b0);
        chk("post_rst_addr", {32'd0, bus_addr}, 64'h54);
        step();
        bus_ack = 1'b0;
        chk_ctl("post_rst_resp", 1'b0, 1'b1, 1'b0);
        chk("post_rst_hrdata", {32'd0, hrdata}, 64'h5555AAAA);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_mpi_ahb_bridge.md
Name: peripheral_mpi_ahb_bridge

Overview:
AHB-Lite slave front-end for the MPI message buffer. It converts the two-phase pipelined AHB protocol (address phase, then data phase) into the generic single-phase bus_en/bus_ack/bus_err handshake. The generic bus is driven by peripheral_mpi_buffer.
The block adds:
- real HREADYOUT wait states;
- a two-cycle ERROR response;
- transfer-legality checks;
- a bounded timeout on the generic side.
It sits between the tile AHB interconnect and the buffer, replacing direct wiring of AHB signals onto the generic bus.

Parameters:
PLEN, 32, AHB address width
XLEN, 32, AHB/generic data width (32 or 64)
TIMEOUT, 16, max data-phase cycles waiting for bus_ack/bus_err before forcing ERROR (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (rst=0 resets on rising clk)
ahb_hsel_i  in  1  slave select
ahb_haddr_i  in  PLEN  address
ahb_hwdata_i  in  XLEN  write data (data phase)
ahb_hwrite_i  in  1  1=write
ahb_hsize_i  in  3  transfer size
ahb_htrans_i  in  2  IDLE/BUSY/NONSEQ/SEQ
ahb_hready_i  in  1  bus-wide HREADY
ahb_hrdata_o  out  XLEN  read data
ahb_hreadyout_o  out  1  slave ready
ahb_hresp_o  out  1  0=OKAY, 1=ERROR
bus_addr  out  PLEN  generic address
bus_we  out  1  generic write enable
bus_en  out  1  generic request
bus_data_in  out  XLEN  generic write data
bus_data_out  in  XLEN  generic read data
bus_ack  in  1  generic completion
bus_err  in  1  generic error completion

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, bus_en=0, bus_we=0, bus_addr=0, bus_data_in=0, state=IDLE, timeout counter=0.
- Reset mid-transfer aborts it: bus_en drops the same cycle the reset is sampled. No response is owed afterwards.
- A transfer is accepted when hsel & htrans[1] & hready_i. On acceptance, latch haddr, hwrite and hsize.
- A transfer is illegal if either:
  - hsize > log2(XLEN/8);
  - haddr is not aligned to hsize.
  An accepted write is also illegal if hsize < log2(XLEN/8), because the generic bus has no byte strobes.
- IDLE/BUSY transfers or hsel=0 produce an OKAY zero-wait response.
- FSM states: IDLE, WCAP, ACCESS, RESP, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0. An accepted transfer goes to:
  - ERR1 if illegal;
  - WCAP if a legal write;
  - ACCESS if a legal read.
- WCAP (first data-phase cycle): hreadyout=0; bus_data_in <= hwdata; next state ACCESS.
- ACCESS: bus_en=1; bus_addr and bus_we come from the latched values; hreadyout=0; the counter increments each cycle.
  - bus_err=1 -> ERR1 (bus_err wins over a simultaneous bus_ack).
  - bus_ack=1 -> RESP; for reads, hrdata <= bus_data_out.
  - counter reaches TIMEOUT -> ERR1.
  - bus_en deasserts on the cycle after ack/err/timeout. The counter clears on leaving ACCESS.
- RESP: hreadyout=1, hresp=0, completing the data phase. A new address phase can be accepted in the same cycle (pipelined back-to-back), with the same next-state rules as IDLE. Otherwise go to IDLE.
- ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1.
  - ERR2 does not accept a new transfer. The master cancels it per AHB-Lite and goes to IDLE.
- Latency:
  - Read with ack in the first ACCESS cycle: 2 data-phase cycles (ACCESS, RESP).
  - Write with ack in the first ACCESS cycle: 3 data-phase cycles (WCAP, ACCESS, RESP).
  - Each extra ack delay adds 1 cycle.
- hrdata holds its value outside RESP. Write transfers do not update hrdata.
- bus_en is never asserted in more than one cycle per generic request after completion; there is no re-issue.

Decomposition:
- Package peripheral_mpi_ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - HSIZE_BYTE..HSIZE_DWORD constants;
  - HRESP_OKAY/ERROR constants;
  - the FSM state typedef.
- A single module with no sub-module. The timeout counter is inline, $clog2(TIMEOUT+1) bits wide.

Test Plan:
- Read NONSEQ haddr=0x10, hsize=2, bus_ack on the 1st ACCESS cycle with bus_data_out=0xCAFE0001 -> bus_en high 1 cycle with bus_addr=0x10 and bus_we=0; RESP cycle has hreadyout=1, hresp=0, hrdata=0xCAFE0001.
- Write haddr=0x20, hwdata=0x12345678, bus_ack delayed 3 cycles -> bus_data_in=0x12345678 and bus_we=1 for 3 cycles; hreadyout low for 4 cycles, then OKAY.
- Byte write (hsize=0) at 0x21 and word read at 0x22 -> bus_en never asserts; ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1) for each.
- bus_ack held low with TIMEOUT=16 -> after exactly 16 ACCESS cycles, bus_en drops and the two-cycle ERROR follows. Repeat with bus_err=bus_ack=1 together -> ERROR.
- Back-to-back reads at 0x0 and 0x4, with the second address phase presented during RESP -> second bus_en starts the cycle after RESP; no idle cycle inserted.
- Drive rst=0 during ACCESS -> next cycle bus_en=0, hreadyout=1, hresp=0, state IDLE; a following read completes normally.
